// File: rtl/regfile_pkg.sv
// Shared types and constants for the multiport integer register file.
package regfile_pkg;

    localparam int RF_XLEN_DEFAULT  = 32;
    localparam int RF_NREGS_DEFAULT = 32;

    typedef enum logic [1:0] {
        RF_IDLE,
        RF_CLEAR,
        RF_DONE
    } rf_state_e;

    function automatic int rf_aw(input int n);
        return $clog2(n);
    endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Bulk-clear sequencer: walks every register address once, gates the write
// port off while doing so, and pulses clr_done when the sweep is finished.
module regfile_clear_fsm
    import regfile_pkg::*;
#(
    parameter int NREGS = RF_NREGS_DEFAULT,
    parameter int AW    = rf_aw(NREGS)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_req,
    output logic          busy,
    output logic          clr_done,
    output logic          wr_ready,
    output logic          clr_en,
    output logic [AW-1:0] clr_addr
);

    localparam logic [AW-1:0] LAST_ADDR = AW'(NREGS - 1);

    rf_state_e     state;
    logic [AW-1:0] cnt;

    // wr_ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= RF_IDLE;
            cnt      <= '0;
            busy     <= 1'b0;
            clr_done <= 1'b0;
            wr_ready <= 1'b0;
        end else begin
            case (state)
                RF_IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_req) begin
                        state    <= RF_CLEAR;
                        cnt      <= '0;
                        busy     <= 1'b1;
                        wr_ready <= 1'b0;
                    end else begin
                        wr_ready <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    if (cnt == LAST_ADDR) begin
                        state    <= RF_DONE;
                        cnt      <= '0;
                        busy     <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                RF_DONE: begin
                    state    <= RF_IDLE;
                    clr_done <= 1'b0;
                    wr_ready <= 1'b1;
                end
                default: begin
                    state    <= RF_IDLE;
                    cnt      <= '0;
                    busy     <= 1'b0;
                    clr_done <= 1'b0;
                    wr_ready <= 1'b0;
                end
            endcase
        end
    end

    assign clr_en   = (state == RF_CLEAR);
    assign clr_addr = cnt;

endmodule

// File: rtl/regfile_multiport.sv
// Integer register file: NRD combinational read ports, one handshaked write
// port, optional hardwired x0, optional write-to-read bypass, bulk clear.
module regfile_multiport
    import regfile_pkg::*;
#(
    parameter int XLEN     = RF_XLEN_DEFAULT,
    parameter int NREGS    = RF_NREGS_DEFAULT,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = rf_aw(NREGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NRD*AW-1:0] rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [AW-1:0]     wr_addr,
    input  logic [XLEN-1:0]   wr_data,
    input  logic              clr_req,
    output logic              busy,
    output logic              clr_done
);

    logic [XLEN-1:0] mem [NREGS];
    logic            clr_en;
    logic [AW-1:0]   clr_addr;
    logic            wr_fire;
    logic            wr_commit;

    regfile_clear_fsm #(
        .NREGS (NREGS),
        .AW    (AW)
    ) u_clear_fsm (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done),
        .wr_ready (wr_ready),
        .clr_en   (clr_en),
        .clr_addr (clr_addr)
    );

    assign wr_fire   = wr_valid && wr_ready;
    assign wr_commit = wr_fire && !((ZERO_REG != 0) && (wr_addr == '0));

    // wr_ready is low during a clear, so the sweep and the write port never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem[i] <= '0;
            end
        end else if (clr_en) begin
            mem[clr_addr] <= '0;
        end else if (wr_commit) begin
            mem[wr_addr] <= wr_data;
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] val;

        assign addr = rd_addr[i*AW +: AW];

        // Bypass only ever triggers on a firing write, hence never during a clear.
        always_comb begin
            val = mem[addr];
            if ((ZERO_REG != 0) && (addr == '0)) begin
                val = '0;
            end else if ((BYPASS != 0) && wr_fire && (addr == wr_addr)) begin
                val = wr_data;
            end
        end

        assign rd_data[i*XLEN +: XLEN] = val;
    end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport: default 32x32 build plus a small
// 3-port, 16-bit, 8-entry build without bypass.
module tb_regfile_multiport;

    typedef enum int {
        K_RD0, K_RD1, K_BUSY, K_RDY, K_DONE,
        K_B0, K_B1, K_B2, K_BBUSY, K_BRDY, K_BDONE
    } chk_e;

    typedef struct {
        chk_e        kind;
        logic [31:0] exp;
        string       name;
    } sb_item_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        clr_req;
    logic        busy;
    logic        clr_done;

    logic [8:0]  b_rd_addr;
    logic [47:0] b_rd_data;
    logic        b_wr_valid;
    logic        b_wr_ready;
    logic [2:0]  b_wr_addr;
    logic [15:0] b_wr_data;
    logic        b_clr_req;
    logic        b_busy;
    logic        b_clr_done;

    sb_item_t sb[$];
    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    regfile_multiport dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .clr_req  (clr_req),
        .busy     (busy),
        .clr_done (clr_done)
    );

    regfile_multiport #(
        .XLEN     (16),
        .NREGS    (8),
        .NRD      (3),
        .ZERO_REG (1),
        .BYPASS   (0)
    ) dut_b (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (b_rd_addr),
        .rd_data  (b_rd_data),
        .wr_valid (b_wr_valid),
        .wr_ready (b_wr_ready),
        .wr_addr  (b_wr_addr),
        .wr_data  (b_wr_data),
        .clr_req  (b_clr_req),
        .busy     (b_busy),
        .clr_done (b_clr_done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                                 input logic clr, input logic [4:0] ra0, input logic [4:0] ra1);
        wr_valid = wv;
        wr_addr  = wa;
        wr_data  = wd;
        clr_req  = clr;
        rd_addr  = {ra1, ra0};
    endtask

    task automatic checkOutput(input chk_e k, input logic [31:0] e, input string nm);
        sb.push_back('{kind: k, exp: e, name: nm});
    endtask

    function automatic logic [31:0] sample(input chk_e k);
        case (k)
            K_RD0:   return rd_data[31:0];
            K_RD1:   return rd_data[63:32];
            K_BUSY:  return {31'b0, busy};
            K_RDY:   return {31'b0, wr_ready};
            K_DONE:  return {31'b0, clr_done};
            K_B0:    return {16'b0, b_rd_data[15:0]};
            K_B1:    return {16'b0, b_rd_data[31:16]};
            K_B2:    return {16'b0, b_rd_data[47:32]};
            K_BBUSY: return {31'b0, b_busy};
            K_BRDY:  return {31'b0, b_wr_ready};
            K_BDONE: return {31'b0, b_clr_done};
            default: return 32'hxxxx_xxxx;
        endcase
    endfunction

    // Monitor: drains every expectation queued for the current cycle at the falling edge.
    always @(negedge clk) begin
        sb_item_t    it;
        logic [31:0] act;
        while (sb.size() != 0) begin
            it  = sb.pop_front();
            act = sample(it.kind);
            n_cmp++;
            if (act !== it.exp) begin
                n_fail++;
                $display("[TB] FAIL %s: actual %h required %h", it.name, act, it.exp);
            end
        end
    end

    initial begin
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd2, 5'd3);
        b_wr_valid = 1'b0;
        b_wr_addr  = 3'd0;
        b_wr_data  = 16'h0;
        b_clr_req  = 1'b0;
        b_rd_addr  = 9'd0;

        $display("[TB] reset");
        #1;
        checkOutput(K_BUSY, 32'd0, "rst_busy");
        checkOutput(K_RDY,  32'd0, "rst_wr_ready");
        checkOutput(K_DONE, 32'd0, "rst_clr_done");
        checkOutput(K_RD0,  32'd0, "rst_rd_x2");
        checkOutput(K_RD1,  32'd0, "rst_rd_x3");
        #11;
        rst_n = 1'b1;
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd1);
        checkOutput(K_RDY,  32'd1, "post_rst_wr_ready");
        checkOutput(K_BUSY, 32'd0, "post_rst_busy");
        checkOutput(K_RD0,  32'd0, "post_rst_rd_x0");
        checkOutput(K_RD1,  32'd0, "post_rst_rd_x1");

        $display("[TB] write and readback");
        applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 5'd1);
        checkOutput(K_RD1, 32'd0, "wr_x5_rd_x1");
        step();
        applyStimulus(1'b1, 5'd31, 32'h12345678, 1'b0, 5'd0, 5'd5);
        checkOutput(K_RD1, 32'hDEADBEEF, "wr_x31_rd_x5");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd5, 5'd31);
        checkOutput(K_RD0, 32'hDEADBEEF, "rd_x5");
        checkOutput(K_RD1, 32'h12345678, "rd_x31");
        step();
        applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 1'b0, 5'd0, 5'd5);
        checkOutput(K_RD0, 32'd0, "wr_x0_same_cycle");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31);
        checkOutput(K_RD0, 32'd0, "rd_x0_after_wr");
        checkOutput(K_RD1, 32'h12345678, "rd_x31_kept");

        $display("[TB] bypass");
        step();
        applyStimulus(1'b1, 5'd7, 32'h11111111, 1'b0, 5'd0, 5'd0);
        step();
        applyStimulus(1'b1, 5'd7, 32'hA5A5A5A5, 1'b0, 5'd7, 5'd5);
        checkOutput(K_RD0, 32'hA5A5A5A5, "bypass_x7");
        checkOutput(K_RD1, 32'hDEADBEEF, "bypass_nomatch_x5");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd7);
        checkOutput(K_RD0, 32'hA5A5A5A5, "x7_port0");
        checkOutput(K_RD1, 32'hA5A5A5A5, "x7_port1");
        step();

        $display("[TB] fill and clear");
        for (int i = 1; i < 32; i++) begin
            applyStimulus(1'b1, i[4:0], 32'(i), 1'b0, 5'd0, 5'd0);
            step();
        end
        applyStimulus(1'b1, 5'd3, 32'h0000CAFE, 1'b1, 5'd3, 5'd31);
        checkOutput(K_RD0,  32'h0000CAFE, "clr_req_wr_bypass");
        checkOutput(K_RD1,  32'd31, "fill_x31");
        checkOutput(K_RDY,  32'd1, "clr_req_wr_ready");
        checkOutput(K_BUSY, 32'd0, "clr_req_busy");
        step();
        applyStimulus(1'b1, 5'd9, 32'h00000099, 1'b0, 5'd9, 5'd20);
        for (int c = 0; c < 32; c++) begin
            checkOutput(K_BUSY, 32'd1, "clr_busy");
            checkOutput(K_RDY,  32'd0, "clr_wr_ready");
            checkOutput(K_DONE, 32'd0, "clr_done_early");
            checkOutput(K_RD0,  (c <= 9)  ? 32'd9  : 32'd0, "clr_rd_x9");
            checkOutput(K_RD1,  (c <= 20) ? 32'd20 : 32'd0, "clr_rd_x20");
            step();
        end
        checkOutput(K_DONE, 32'd1, "done_pulse");
        checkOutput(K_BUSY, 32'd0, "done_busy");
        checkOutput(K_RDY,  32'd0, "done_wr_ready");
        checkOutput(K_RD0,  32'd0, "done_rd_x9");
        checkOutput(K_RD1,  32'd0, "done_rd_x20");
        step();
        checkOutput(K_RDY,  32'd1, "idle_wr_ready");
        checkOutput(K_DONE, 32'd0, "done_one_cycle");
        checkOutput(K_RD0,  32'h00000099, "held_wr_bypass");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd9, 5'd3);
        checkOutput(K_RD0, 32'h00000099, "held_wr_landed");
        checkOutput(K_RD1, 32'd0, "x3_cleared");
        step();

        $display("[TB] reset mid-clear");
        applyStimulus(1'b1, 5'd20, 32'h00002020, 1'b0, 5'd20, 5'd9);
        checkOutput(K_RD0, 32'h00002020, "wr_x20_bypass");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 5'd20, 5'd9);
        checkOutput(K_RD1, 32'h00000099, "pre_clr_x9");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd20, 5'd9);
        repeat (10) step();
        checkOutput(K_BUSY, 32'd1, "mid_clr_busy");
        checkOutput(K_RD0,  32'h00002020, "mid_clr_x20");
        checkOutput(K_RD1,  32'd0, "mid_clr_x9");
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        checkOutput(K_BUSY, 32'd0, "rst_mid_busy");
        checkOutput(K_RDY,  32'd0, "rst_mid_wr_ready");
        checkOutput(K_DONE, 32'd0, "rst_mid_done");
        checkOutput(K_RD0,  32'd0, "rst_mid_x20");
        step();
        checkOutput(K_BUSY, 32'd0, "rst_hold_busy");
        checkOutput(K_DONE, 32'd0, "rst_hold_done");
        rst_n = 1'b1;
        step();
        checkOutput(K_RDY,  32'd1, "rel_wr_ready");
        checkOutput(K_BUSY, 32'd0, "rel_busy");
        checkOutput(K_DONE, 32'd0, "rel_no_done");
        applyStimulus(1'b1, 5'd6, 32'h00000066, 1'b0, 5'd6, 5'd20);
        checkOutput(K_RD0, 32'h00000066, "rel_wr_bypass");
        checkOutput(K_RD1, 32'd0, "rel_x20");
        step();
        applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 5'd6, 5'd6);
        checkOutput(K_RD0, 32'h00000066, "rel_x6_p0");
        checkOutput(K_RD1, 32'h00000066, "rel_x6_p1");
        step();

        $display("[TB] small build, no bypass");
        b_wr_valid = 1'b1;
        b_wr_addr  = 3'd5;
        b_wr_data  = 16'h1234;
        b_rd_addr  = {3'd5, 3'd5, 3'd5};
        checkOutput(K_BRDY, 32'd1, "b_wr_ready");
        checkOutput(K_B0, 32'd0, "b_nobypass_p0");
        checkOutput(K_B1, 32'd0, "b_nobypass_p1");
        checkOutput(K_B2, 32'd0, "b_nobypass_p2");
        step();
        b_wr_valid = 1'b0;
        checkOutput(K_B0, 32'h1234, "b_x5_p0");
        checkOutput(K_B1, 32'h1234, "b_x5_p1");
        checkOutput(K_B2, 32'h1234, "b_x5_p2");
        b_clr_req = 1'b1;
        step();
        b_clr_req = 1'b0;
        for (int c = 0; c < 8; c++) begin
            checkOutput(K_BBUSY, 32'd1, "b_clr_busy");
            checkOutput(K_BRDY,  32'd0, "b_clr_wr_ready");
            checkOutput(K_BDONE, 32'd0, "b_clr_done_early");
            step();
        end
        checkOutput(K_BDONE, 32'd1, "b_done_pulse");
        checkOutput(K_BBUSY, 32'd0, "b_done_busy");
        checkOutput(K_B0, 32'd0, "b_cleared_p0");
        checkOutput(K_B2, 32'd0, "b_cleared_p2");
        step();
        checkOutput(K_BRDY,  32'd1, "b_idle_wr_ready");
        checkOutput(K_BDONE, 32'd0, "b_done_one_cycle");

        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_fail++;
            $display("[TB] FAIL scoreboard_drain: actual %0d pending required 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
